// File: rtl/cpu_out_capture.sv
// Output-port sink for the lab CPU: FWFT byte FIFO with valid/ready drain and halt/done tracking.
// Optional: define CAPTURE_CHECKSUM_EN to add a running mod-256 checksum of accepted bytes.
module cpu_out_capture #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    cpu_out,
  input  logic          cpu_out_we,
  input  logic          cpu_halt,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   byte_cnt,
  output logic          done
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [7:0]    checksum
`endif
);

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_next;
  logic [AW:0]     level_after_pop, level_next;
  logic            pop, push_req, accept, drop;

  assign m_valid = (level != '0);

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  always_comb begin
    pop             = m_valid & m_ready;
    push_req        = cpu_out_we & (state == ST_RUN);
    accept          = push_req & ((level != FULL_LEVEL) | pop);
    drop            = push_req & (level == FULL_LEVEL) & ~pop;
    level_after_pop = pop ? (level - LVL_ONE) : level;
    level_next      = accept ? (level_after_pop + LVL_ONE) : level_after_pop;
    rd_next         = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (cpu_halt) state_next = ST_DRAIN;
      ST_DRAIN: if (level_after_pop == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= cpu_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      done     <= 1'b0;
      level    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      m_data   <= 8'h00;
      overflow <= 1'b0;
      byte_cnt <= 16'h0000;
    end else begin
      state  <= state_next;
      done   <= (state_next == ST_DONE);
      level  <= level_next;
      rd_ptr <= rd_next;
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
      if (accept && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
      // Head register: bypass the incoming byte into an emptying FIFO, otherwise follow the read pointer.
      if (accept && level_after_pop == '0)
        m_data <= cpu_out;
      else if (level_after_pop != '0)
        m_data <= mem[rd_next];
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      checksum <= 8'h00;
    else if (accept)
      checksum <= checksum + cpu_out;
  end
`endif

endmodule

// File: tb/tb_cpu_out_capture.sv
// Self-checking bench for cpu_out_capture: vector table, directed corner sequences, randomized model compare.
module tb_cpu_out_capture;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    cpu_out = 8'h00;
  logic          cpu_out_we = 1'b0;
  logic          cpu_halt = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic          overflow;
  logic [15:0]   byte_cnt;
  logic          done;
`ifdef CAPTURE_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_out_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cpu_out(cpu_out), .cpu_out_we(cpu_out_we), .cpu_halt(cpu_halt),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .overflow(overflow), .byte_cnt(byte_cnt), .done(done)
`ifdef CAPTURE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Reference model: the FIFO is a queue, halt/done are two flags.
  logic [7:0]  mq[$];
  logic [7:0]  m_last;
  int          m_cnt;
  bit          m_ovf, m_done, m_halted;
  logic [7:0]  m_sum;

  task automatic modelReset();
    mq.delete();
    m_last = 8'h00; m_cnt = 0; m_ovf = 0; m_done = 0; m_halted = 0; m_sum = 8'h00;
  endtask

  task automatic modelStep(input logic we, input logic [7:0] din, input logic halt, input logic ready);
    if (mq.size() != 0 && ready) void'(mq.pop_front());
    if (we && !m_halted) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(din);
        if (m_cnt < 65535) m_cnt++;
        m_sum = m_sum + din;
      end else begin
        m_ovf = 1;
      end
    end
    if (m_halted && mq.size() == 0) m_done = 1;
    if (halt) m_halted = 1;
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    checkOutput("m_data", 32'(m_data), 32'(m_last));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    checkOutput("done", 32'(done), 32'(m_done));
`ifdef CAPTURE_CHECKSUM_EN
    checkOutput("checksum", 32'(checksum), 32'(m_sum));
`endif
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] din, input logic halt, input logic ready);
    cpu_out_we = we; cpu_out = din; cpu_halt = halt; m_ready = ready;
    @(posedge clk);
    modelStep(we, din, halt, ready);
    @(negedge clk);
  endtask

  task automatic doReset();
    cpu_out_we = 1'b0; cpu_out = 8'h00; cpu_halt = 1'b0; m_ready = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_valid", 32'(m_valid), 0);
    checkOutput("rst_data", 32'(m_data), 0);
    checkOutput("rst_cnt", 32'(byte_cnt), 0);
    checkOutput("rst_ovf", 32'(overflow), 0);
    checkOutput("rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  din;
    logic        halt;
    logic        ready;
    logic [3:0]  lvl;
    logic        vld;
    logic [7:0]  dat;
    logic        ovf;
    logic [15:0] cnt;
    logic        dn;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 8'h42, 1'b0, 1'b1, 4'd1, 1'b1, 8'h42, 1'b0, 16'd1, 1'b0};
    vecs[1] = '{1'b1, 8'h43, 1'b0, 1'b1, 4'd1, 1'b1, 8'h43, 1'b0, 16'd2, 1'b0};
    vecs[2] = '{1'b1, 8'h44, 1'b0, 1'b1, 4'd1, 1'b1, 8'h44, 1'b0, 16'd3, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h44, 1'b0, 16'd3, 1'b0};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 4'd1, 1'b1, 8'h55, 1'b0, 16'd4, 1'b0};
    vecs[5] = '{1'b1, 8'h66, 1'b0, 1'b0, 4'd2, 1'b1, 8'h55, 1'b0, 16'd5, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1, 8'h66, 1'b0, 16'd5, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h66, 1'b0, 16'd5, 1'b0};

    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].din, vecs[i].halt, vecs[i].ready);
      checkOutput("vec_level", 32'(level), 32'(vecs[i].lvl));
      checkOutput("vec_valid", 32'(m_valid), 32'(vecs[i].vld));
      checkOutput("vec_data", 32'(m_data), 32'(vecs[i].dat));
      checkOutput("vec_ovf", 32'(overflow), 32'(vecs[i].ovf));
      checkOutput("vec_cnt", 32'(byte_cnt), 32'(vecs[i].cnt));
      checkOutput("vec_done", 32'(done), 32'(vecs[i].dn));
`ifdef CAPTURE_CHECKSUM_EN
      if (i == 2) checkOutput("checksum_424344", 32'(checksum), 32'h0C9);
`endif
    end

    // Overflow: nine pushes into an eight-deep FIFO, the ninth is lost.
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("ovf_level", 32'(level), 8);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("ovf_cnt", 32'(byte_cnt), 8);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("ovf_drain_data", 32'(m_data), 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("ovf_empty_valid", 32'(m_valid), 0);
    checkOutput("ovf_sticky", 32'(overflow), 1);

    // Full FIFO with a simultaneous pop accepts the new byte.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    checkOutput("full_pp_level", 32'(level), 8);
    checkOutput("full_pp_ovf", 32'(overflow), 0);
    checkOutput("full_pp_cnt", 32'(byte_cnt), 9);
    for (int i = 0; i < 8; i++) begin
      checkOutput("full_pp_data", 32'(m_data), (i == 7) ? 32'h0AA : 32'(8'h12 + 8'(i)));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("full_pp_empty", 32'(level), 0);

    // Halt with queued bytes: later writes ignored, done on the final pop.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h24, 1'b1, 1'b0);
    checkOutput("halt_level", 32'(level), 3);
    checkOutput("halt_cnt", 32'(byte_cnt), 3);
    checkOutput("halt_ovf", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("halt_data", 32'(m_data), 32'(8'h21 + 8'(i)));
      checkOutput("halt_done_early", 32'(done), 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    end
    checkOutput("halt_done", 32'(done), 1);
    checkOutput("halt_final_cnt", 32'(byte_cnt), 3);

    // Halt while empty: done two clocks later, and sticky after halt drops.
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("empty_halt_done1", 32'(done), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("empty_halt_done2", 32'(done), 1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b1);
    checkOutput("done_sticky", 32'(done), 1);
    checkOutput("done_no_push", 32'(level), 0);

    // Asynchronous reset mid-stream, with overflow set and five bytes queued.
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("pre_async_level", 32'(level), 5);
    rst = 1'b0;
    #1;
    checkOutput("async_level", 32'(level), 0);
    checkOutput("async_valid", 32'(m_valid), 0);
    checkOutput("async_cnt", 32'(byte_cnt), 0);
    checkOutput("async_ovf", 32'(overflow), 0);
    checkOutput("async_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();

    // Randomized episodes against the queue model, each ending in halt and drain.
    for (int ep = 0; ep < 3; ep++) begin
      doReset();
      for (int c = 0; c < 300; c++) begin
        applyStimulus($urandom_range(0, 99) < 60, 8'($urandom), c >= 150 + ep * 40,
                      $urandom_range(0, 99) < 30 + ep * 20);
        checkModel();
      end
      for (int c = 0; c < 12; c++) begin
        applyStimulus($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 1'b1);
        checkModel();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
